rv_branch_unit: RTL and testbench

Registered branch resolution unit with a built-in 2-bit saturating branch history table (BHT). It evaluates the six RV32I/RV64I branch conditions at parametrised width in EX and predicts direction for the fetch stage. It also flags mispredictions with a redirect PC one cycle later and keeps saturating branch/mispredict statistics. It sits between the EX operand muxes and the IF PC-select logic.

---
 rtl/rv_branch_unit.sv | 134 +++++++++++++
 tb/tb_rv_branch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_branch_unit.sv
// Registered branch resolution unit with a 2-bit saturating branch history table.
// Resolves RV32I/RV64I branch conditions, predicts for fetch and keeps branch/mispredict stats.
module rv_branch_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_flush,
  input  logic [2:0]       ex_branchOp,
  input  logic [XLEN-1:0]  ex_srcA,
  input  logic [XLEN-1:0]  ex_srcB,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [XLEN-1:0]  res_redirect_pc,
  output logic             res_illegal,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ctr_old;
  logic [1:0]       ctr_new;

  logic acc, legal, taken, upd, mis;
  logic eq, lt_s, lt_u;
  logic [XLEN-1:0] redirect;

  logic            res_valid_q, res_valid_d;
  logic            res_taken_q, res_taken_d;
  logic            res_mis_q, res_mis_d;
  logic            res_ill_q, res_ill_d;
  logic [XLEN-1:0] res_rpc_q, res_rpc_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mis_q, stat_mis_d;

  assign pred_idx   = pred_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  // Read is taken from the registered table, so a same-index update is not bypassed.
  assign pred_taken = bht_q[pred_idx][1];

  assign acc  = ex_valid & ~ex_flush;
  assign eq   = (ex_srcA == ex_srcB);
  assign lt_s = ($signed(ex_srcA) < $signed(ex_srcB));
  assign lt_u = (ex_srcA < ex_srcB);

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (ex_branchOp)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt_s;
      3'b101:  taken = ~lt_s;
      3'b110:  taken = lt_u;
      3'b111:  taken = ~lt_u;
      default: legal = 1'b0;
    endcase
  end

  assign upd      = acc & legal;
  assign mis      = upd & (taken != ex_pred_taken);
  assign redirect = taken ? ex_target : ex_pc + {{(XLEN-3){1'b0}}, 3'd4};

  assign ctr_old = bht_q[ex_idx];
  always_comb begin
    ctr_new = ctr_old;
    if (taken && ctr_old != 2'b11)
      ctr_new = ctr_old + 2'b01;
    else if (!taken && ctr_old != 2'b00)
      ctr_new = ctr_old - 2'b01;
  end

  always_comb begin
    res_valid_d = acc;
    res_mis_d   = mis;
    res_taken_d = acc ? taken  : res_taken_q;
    res_ill_d   = acc ? ~legal : res_ill_q;
    res_rpc_d   = acc ? redirect : res_rpc_q;
    stat_br_d   = (upd && stat_br_q != '1) ? stat_br_q + CNT_W'(1) : stat_br_q;
    stat_mis_d  = (mis && stat_mis_q != '1) ? stat_mis_q + CNT_W'(1) : stat_mis_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_mis_q   <= 1'b0;
      res_ill_q   <= 1'b0;
      res_rpc_q   <= '0;
      stat_br_q   <= '0;
      stat_mis_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      res_mis_q   <= res_mis_d;
      res_ill_q   <= res_ill_d;
      res_rpc_q   <= res_rpc_d;
      stat_br_q   <= stat_br_d;
      stat_mis_q  <= stat_mis_d;
    end
  end

  // Counters come up weakly not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= 2'b01;
    end else if (upd) begin
      bht_q[ex_idx] <= ctr_new;
    end
  end

  assign res_valid        = res_valid_q;
  assign res_taken        = res_taken_q;
  assign res_mispredict   = res_mis_q;
  assign res_illegal      = res_ill_q;
  assign res_redirect_pc  = res_rpc_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_rv_branch_unit.sv
// Scoreboard bench for rv_branch_unit: a 32-bit instance with 4-bit stats is fully modelled,
// a 64-bit twin sees sign-extended operands and has its direction checked every cycle.
module tb_rv_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        ex_valid, ex_flush, ex_pred_taken;
  logic [2:0]  ex_branchOp;
  logic [31:0] ex_srcA, ex_srcB, ex_pc, ex_target;
  logic        res_valid, res_taken, res_mispredict, res_illegal;
  logic [31:0] res_redirect_pc;
  logic [3:0]  stat_branches, stat_mispredicts;

  logic [63:0] a64, b64, pc64, tgt64, ppc64, rpc64;
  logic        pt64, rv64, rt64, rm64, ri64;
  logic [3:0]  sb64, sm64;

  assign a64   = {{32{ex_srcA[31]}}, ex_srcA};
  assign b64   = {{32{ex_srcB[31]}}, ex_srcB};
  assign pc64  = {32'h0, ex_pc};
  assign tgt64 = {32'h0, ex_target};
  assign ppc64 = {32'h0, pred_pc};

  always #5 clk = ~clk;

  rv_branch_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_branchOp(ex_branchOp),
    .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_redirect_pc(res_redirect_pc),
    .res_illegal(res_illegal), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  rv_branch_unit #(.XLEN(64), .BHT_ENTRIES(64), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .pred_pc(ppc64), .pred_taken(pt64),
    .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_branchOp(ex_branchOp),
    .ex_srcA(a64), .ex_srcB(b64), .ex_pc(pc64), .ex_target(tgt64),
    .ex_pred_taken(ex_pred_taken), .res_valid(rv64), .res_taken(rt64),
    .res_mispredict(rm64), .res_redirect_pc(rpc64),
    .res_illegal(ri64), .stat_branches(sb64),
    .stat_mispredicts(sm64)
  );

  typedef struct packed {
    logic        v;
    logic        t;
    logic        m;
    logic        il;
    logic [31:0] rpc;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  bht_m [64];
  logic [3:0]  br_m, mis_m;
  logic        held_t, held_il;
  logic [31:0] held_rpc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_f(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  // Returns {legal, taken}.
  function automatic logic [1:0] eval_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return {1'b1, a == b};
      3'b001:  return {1'b1, a != b};
      3'b100:  return {1'b1, $signed(a) < $signed(b)};
      3'b101:  return {1'b1, $signed(a) >= $signed(b)};
      3'b110:  return {1'b1, a < b};
      3'b111:  return {1'b1, a >= b};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic pred_m(input logic [31:0] pc);
    return bht_m[idx_f(pc)][1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    br_m = 0; mis_m = 0; held_t = 0; held_il = 0; held_rpc = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_valid = 1'b1; ex_flush = 1'b0; ex_branchOp = 3'b000;
    ex_srcA = 32'h5; ex_srcB = 32'h5; ex_pc = 32'h100; ex_target = 32'h400;
    ex_pred_taken = 1'b0; pred_pc = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_valid", res_valid, 0);
    chk("rst_taken", res_taken, 0);
    chk("rst_mis", res_mispredict, 0);
    chk("rst_ill", res_illegal, 0);
    chk("rst_rpc", res_redirect_pc, 0);
    chk("rst_sbr", stat_branches, 0);
    chk("rst_smis", stat_mispredicts, 0);
    pred_pc = 32'h0;  #1 chk("rst_pred0", pred_taken, 0);
    pred_pc = 32'h4;  #1 chk("rst_pred4", pred_taken, 0);
    pred_pc = 32'hFC; #1 chk("rst_predFC", pred_taken, 0);
    rst = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic f, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ppc);
    logic [1:0] lt;
    logic       acc;
    int         ix;
    exp_t       e;
    ex_valid = v; ex_flush = f; ex_branchOp = op; ex_srcA = a; ex_srcB = b;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; pred_pc = ppc;
    #1;
    chk("pred_pre", pred_taken, pred_m(ppc));
    lt  = eval_f(op, a, b);
    acc = v & ~f;
    if (acc) begin
      held_t   = lt[0];
      held_il  = ~lt[1];
      held_rpc = lt[0] ? tgt : pc + 32'd4;
    end
    e.v = acc; e.t = held_t; e.il = held_il; e.rpc = held_rpc;
    e.m = acc & lt[1] & (lt[0] != pt);
    if (acc & lt[1]) begin
      ix = idx_f(pc);
      if (lt[0] && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'b01;
      else if (!lt[0] && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'b01;
      if (br_m != 4'hF) br_m = br_m + 4'h1;
      if (e.m && mis_m != 4'hF) mis_m = mis_m + 4'h1;
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk("res_valid", res_valid, e.v);
    chk("res_taken", res_taken, e.t);
    chk("res_mis", res_mispredict, e.m);
    chk("res_ill", res_illegal, e.il);
    chk("res_rpc", res_redirect_pc, e.rpc);
    chk("stat_br", stat_branches, br_m);
    chk("stat_mis", stat_mispredicts, mis_m);
    chk("pred_post", pred_taken, pred_m(ppc));
    chk("taken64", rt64, e.t);
  endtask

  task automatic tr(input logic taken_dir, input logic [31:0] pc, input logic [31:0] ppc);
    // BEQ on equal/unequal operands, prediction carried from the model at pc.
    cycle(1, 0, 3'b000, 32'h7, taken_dir ? 32'h7 : 32'h8, pc, 32'h800, pred_m(pc), ppc);
  endtask

  initial begin
    logic [2:0]  ops [6];
    logic [2:0]  op;
    logic [31:0] ra, rb, rpc;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100;
    ops[3] = 3'b101; ops[4] = 3'b110; ops[5] = 3'b111;

    do_reset();

    // Signed vs unsigned; 64-bit twin sees -1 vs 1.
    cycle(1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h1000, 0, 32'h40);
    chk("blt_taken", res_taken, 1);
    cycle(1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h1000, 0, 32'h40);
    chk("bltu_taken", res_taken, 0);
    cycle(1, 0, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h1000, 0, 32'h40);
    chk("bge_taken", res_taken, 0);
    cycle(1, 0, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h1000, 0, 32'h40);
    chk("bgeu_taken", res_taken, 1);
    chk("bgeu64_taken", rt64, 1);
    cycle(1, 0, 3'b000, 32'h1234, 32'h1234, 32'h40, 32'h1000, 0, 32'h40);
    chk("beq_taken", res_taken, 1);

    // Training at 0x100: 01->10->11->11, then down to 00.
    for (int i = 0; i < 3; i++) tr(1, 32'h100, 32'h100);
    for (int i = 0; i < 3; i++) tr(0, 32'h100, 32'h100);
    chk("sat_low_pred", pred_taken, 0);
    tr(1, 32'h100, 32'h100);
    chk("from00_pred", pred_taken, 0);

    // Aliasing 0x100 / 0x200 with read-during-write on pred_pc=0x100.
    for (int i = 0; i < 3; i++) tr(1, 32'h100, 32'h100);
    tr(0, 32'h200, 32'h100);
    tr(0, 32'h200, 32'h100);
    chk("alias_new", pred_taken, 0);

    // Flush and illegal op.
    cycle(1, 1, 3'b000, 32'h1, 32'h1, 32'h100, 32'h900, 0, 32'h100);
    chk("flush_valid", res_valid, 0);
    cycle(1, 0, 3'b010, 32'h1, 32'h1, 32'h100, 32'h900, 1, 32'h100);
    chk("illegal_flag", res_illegal, 1);
    cycle(0, 0, 3'b011, 32'h1, 32'h2, 32'h104, 32'h900, 0, 32'h104);

    // Redirect wrap.
    cycle(1, 0, 3'b001, 32'h3, 32'h3, 32'hFFFF_FFFC, 32'h900, 0, 32'hFFFF_FFFC);
    chk("rpc_wrap", res_redirect_pc, 32'h0);

    for (int i = 0; i < 40; i++) begin
      op  = ops[$urandom_range(0, 5)];
      ra  = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'($urandom_range(0, 7));
      rb  = 32'($urandom_range(0, 7)) - 32'd2;
      rpc = 32'h100 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) op = 3'b011;
      cycle($urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0, op, ra, rb, rpc,
            $urandom, pred_m(rpc), rpc ^ 32'h4);
    end

    // Mid-stream reset, then stat saturation with CNT_W=4.
    ex_valid = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) tr(i % 2 == 0, 32'h300, 32'h300);
    chk("stat_sat", stat_branches, 4'd15);
    cycle(0, 0, 3'b000, 32'h0, 32'h0, 32'h300, 32'h0, 0, 32'h300);
    chk("stat_hold", stat_branches, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
